// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
// Byte0 field positions follow the standard 3-byte stream-mode packet.
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  // byte0 bit positions; BTN is the LSB of the 3-bit {middle, right, left} field
  localparam int BTN   = 0;
  localparam int ALIGN = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    PK_BYTE0,
    PK_BYTE1,
    PK_BYTE2
  } packet_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deserialiser with idle timeout.
// Byte outputs are combinational strobes on the stop-bit falling edge.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     i_ps2_clk,
  input  logic                     i_ps2_data,
  input  logic                     i_pkt_busy,
  output logic [PS2_DATA_BITS-1:0] o_byte,
  output logic                     o_byte_valid,
  output logic                     o_byte_error,
  output logic                     o_timeout
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_DATA_BITS);

  logic [1:0]               r_clk_sync;
  logic [1:0]               r_data_sync;
  logic                     r_clk_filt;
  logic [FW-1:0]            r_filt_cnt;
  logic [TW-1:0]            r_to_cnt;
  logic [BW-1:0]            r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_par;
  frame_state_t             r_state;
  frame_state_t             w_state_nxt;

  logic w_clk_s;
  logic w_data;
  logic w_filt_done;
  logic w_fall;
  logic w_par_ok;

  assign w_clk_s     = r_clk_sync[1];
  assign w_data      = r_data_sync[1];
  assign w_filt_done = (r_filt_cnt == FW'(FILTER_LEN - 1));
  // The filtered level flips only after FILTER_LEN consecutive differing samples
  assign w_fall      = r_clk_filt & ~w_clk_s & w_filt_done;
  assign w_par_ok    = ^{r_shift, r_par};
  assign o_timeout   = ((r_state != FR_IDLE) || i_pkt_busy) && !w_fall &&
                       (r_to_cnt == TW'(TIMEOUT_CYCLES));
  assign o_byte      = r_shift;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_filt  <= 1'b1;
      r_filt_cnt  <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      if (w_clk_s == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (w_filt_done) begin
        r_clk_filt <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
      if (w_fall) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= FR_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_byte_valid = 1'b0;
    o_byte_error = 1'b0;
    if (o_timeout) begin
      w_state_nxt = FR_IDLE;
    end else if (w_fall) begin
      case (r_state)
        FR_IDLE:   if (!w_data) w_state_nxt = FR_DATA;
        FR_DATA:   if (r_bit_cnt == BW'(PS2_DATA_BITS - 1)) w_state_nxt = FR_PARITY;
        FR_PARITY: w_state_nxt = FR_STOP;
        FR_STOP: begin
          w_state_nxt  = FR_IDLE;
          o_byte_valid = w_par_ok & w_data;
          o_byte_error = ~(w_par_ok & w_data);
        end
        default:   w_state_nxt = FR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else if (w_fall) begin
      case (r_state)
        FR_IDLE:   r_bit_cnt <= '0;
        FR_DATA: begin
          r_shift   <= {w_data, r_shift[PS2_DATA_BITS-1:1]};
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
        FR_PARITY: r_par <= w_data;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_mouse_receiver.sv
// PS/2 mouse packet assembler: 3-byte stream packets to sign/magnitude
// movement with a one-cycle valid pulse and held button state.
module ps2_mouse_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_mouse_dx,
  output logic [7:0] o_mouse_dy,
  output logic       o_is_mouse_dx_neg,
  output logic       o_is_mouse_dy_neg,
  output logic [2:0] o_buttons,
  output logic       o_packet_valid,
  output logic       o_frame_error
);

  logic [PS2_DATA_BITS-1:0] w_byte;
  logic                     w_byte_valid;
  logic                     w_byte_error;
  logic                     w_timeout;
  logic                     w_pkt_busy;

  packet_state_t r_pkt_state;
  packet_state_t w_pkt_nxt;
  logic          w_load_b0;
  logic          w_load_b1;
  logic          w_emit;
  logic          w_align_err;

  logic [2:0] r_b0_btn;
  logic       r_b0_xs;
  logic       r_b0_ys;
  logic       r_b0_xo;
  logic       r_b0_yo;
  logic [7:0] r_b1;

  logic [7:0] r_mouse_dx;
  logic [7:0] r_mouse_dy;
  logic       r_dx_neg;
  logic       r_dy_neg;
  logic [2:0] r_buttons;
  logic       r_packet_valid;
  logic       r_frame_error;

  // 9-bit two's complement {sign, byte} to 8-bit magnitude, saturating -256 and overflow
  function automatic logic [7:0] sat_mag(input logic sign, input logic [7:0] mag_in,
                                         input logic ovf);
    logic signed [9:0] v;
    logic signed [9:0] n;
    v = $signed({sign, sign, mag_in});
    n = -v;
    if (ovf)           return 8'hFF;
    if (!sign)         return mag_in;
    if (n > 10'sd255)  return 8'hFF;
    return n[7:0];
  endfunction

  assign w_pkt_busy = (r_pkt_state != PK_BYTE0);

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .i_pkt_busy  (w_pkt_busy),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_byte_error(w_byte_error),
    .o_timeout   (w_timeout)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_pkt_state <= PK_BYTE0;
    end else begin
      r_pkt_state <= w_pkt_nxt;
    end
  end

  always_comb begin
    w_pkt_nxt   = r_pkt_state;
    w_load_b0   = 1'b0;
    w_load_b1   = 1'b0;
    w_emit      = 1'b0;
    w_align_err = 1'b0;
    if (w_timeout || w_byte_error) begin
      w_pkt_nxt = PK_BYTE0;
    end else if (w_byte_valid) begin
      case (r_pkt_state)
        PK_BYTE0: begin
          if (w_byte[ALIGN]) begin
            w_load_b0 = 1'b1;
            w_pkt_nxt = PK_BYTE1;
          end else begin
            w_align_err = 1'b1;
          end
        end
        PK_BYTE1: begin
          w_load_b1 = 1'b1;
          w_pkt_nxt = PK_BYTE2;
        end
        PK_BYTE2: begin
          w_emit    = 1'b1;
          w_pkt_nxt = PK_BYTE0;
        end
        default:  w_pkt_nxt = PK_BYTE0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_b0_btn <= '0;
      r_b0_xs  <= 1'b0;
      r_b0_ys  <= 1'b0;
      r_b0_xo  <= 1'b0;
      r_b0_yo  <= 1'b0;
      r_b1     <= '0;
    end else begin
      if (w_load_b0) begin
        r_b0_btn <= w_byte[BTN+2:BTN];
        r_b0_xs  <= w_byte[XS];
        r_b0_ys  <= w_byte[YS];
        r_b0_xo  <= w_byte[XO];
        r_b0_yo  <= w_byte[YO];
      end
      if (w_load_b1) r_b1 <= w_byte;
    end
  end

  // Output stage: movement is zero except in the single valid cycle
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mouse_dx     <= '0;
      r_mouse_dy     <= '0;
      r_dx_neg       <= 1'b0;
      r_dy_neg       <= 1'b0;
      r_buttons      <= '0;
      r_packet_valid <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_packet_valid <= w_emit;
      r_frame_error  <= w_byte_error | w_timeout | w_align_err;
      if (w_emit) begin
        r_mouse_dx <= sat_mag(r_b0_xs, r_b1, r_b0_xo);
        r_mouse_dy <= sat_mag(r_b0_ys, w_byte, r_b0_yo);
        r_dx_neg   <= r_b0_xs;
        r_dy_neg   <= r_b0_ys;
        r_buttons  <= r_b0_btn;
      end else begin
        r_mouse_dx <= '0;
        r_mouse_dy <= '0;
        r_dx_neg   <= 1'b0;
        r_dy_neg   <= 1'b0;
      end
    end
  end

  assign o_mouse_dx        = r_mouse_dx;
  assign o_mouse_dy        = r_mouse_dy;
  assign o_is_mouse_dx_neg = r_dx_neg;
  assign o_is_mouse_dy_neg = r_dy_neg;
  assign o_buttons         = r_buttons;
  assign o_packet_valid    = r_packet_valid;
  assign o_frame_error     = r_frame_error;

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// Bench for ps2_mouse_receiver: bit-banged PS/2 frames, pulse monitor and
// an arithmetic reference model of the packet-to-movement conversion.
module tb_ps2_mouse_receiver;

  localparam int FLT  = 8;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] o_mouse_dx;
  logic [7:0] o_mouse_dy;
  logic       o_is_mouse_dx_neg;
  logic       o_is_mouse_dy_neg;
  logic [2:0] o_buttons;
  logic       o_packet_valid;
  logic       o_frame_error;

  always #5 clk = ~clk;

  ps2_mouse_receiver #(
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .i_ps2_clk        (ps2_clk),
    .i_ps2_data       (ps2_data),
    .o_mouse_dx       (o_mouse_dx),
    .o_mouse_dy       (o_mouse_dy),
    .o_is_mouse_dx_neg(o_is_mouse_dx_neg),
    .o_is_mouse_dy_neg(o_is_mouse_dy_neg),
    .o_buttons        (o_buttons),
    .o_packet_valid   (o_packet_valid),
    .o_frame_error    (o_frame_error)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_leak   = 0;
  logic [7:0] cap_dx, cap_dy;
  logic       cap_dxn, cap_dyn;
  logic [2:0] cap_btn;

  // Pulse monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (o_packet_valid) begin
      n_valid++;
      cap_dx  = o_mouse_dx;
      cap_dy  = o_mouse_dy;
      cap_dxn = o_is_mouse_dx_neg;
      cap_dyn = o_is_mouse_dy_neg;
      cap_btn = o_buttons;
    end else if (o_mouse_dx != 8'd0 || o_mouse_dy != 8'd0 ||
                 o_is_mouse_dx_neg || o_is_mouse_dy_neg) begin
      n_leak++;
    end
    if (o_frame_error) n_ferr++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Device-to-host frame: data changes while clock high, host samples on the falling edge
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  // Reference: magnitude of the 9-bit movement value, clipped to 255
  function automatic int ref_mag(input logic sign, input logic [7:0] b, input logic ovf);
    int v;
    v = sign ? int'(b) - 256 : int'(b);
    if (ovf) return 255;
    if (v < 0) v = -v;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic send_and_check(input string tag, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2);
    int v0, e0;
    v0 = n_valid;
    e0 = n_ferr;
    send_frame(b0, 1'b0, 11);
    send_frame(b1, 1'b0, 11);
    send_frame(b2, 1'b0, 11);
    wait_cyc(5);
    chk({tag, ".valid_cnt"}, n_valid - v0, 1);
    chk({tag, ".err_cnt"},   n_ferr - e0, 0);
    chk({tag, ".dx"},        cap_dx,  ref_mag(b0[4], b1, b0[6]));
    chk({tag, ".dx_neg"},    cap_dxn, b0[4]);
    chk({tag, ".dy"},        cap_dy,  ref_mag(b0[5], b2, b0[7]));
    chk({tag, ".dy_neg"},    cap_dyn, b0[5]);
    chk({tag, ".buttons"},   cap_btn, b0[2:0]);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] rb0, rb1, rb2;
    logic [2:0] btn_hold;

    wait_cyc(5);
    @(negedge clk);
    chk("rst.dx",    o_mouse_dx, 0);
    chk("rst.dy",    o_mouse_dy, 0);
    chk("rst.dxn",   o_is_mouse_dx_neg, 0);
    chk("rst.dyn",   o_is_mouse_dy_neg, 0);
    chk("rst.btn",   o_buttons, 0);
    chk("rst.valid", o_packet_valid, 0);
    chk("rst.err",   o_frame_error, 0);
    arst_n = 1'b1;
    wait_cyc(50);

    send_and_check("basic",  8'h29, 8'h05, 8'hFD);
    send_and_check("xovf",   8'h58, 8'h10, 8'h00);
    send_and_check("xm256",  8'h18, 8'h00, 8'h00);

    // Bad parity on byte1
    btn_hold = cap_btn;
    v0 = n_valid; e0 = n_ferr;
    send_frame(8'h0A, 1'b0, 11);
    send_frame(8'h33, 1'b1, 11);
    wait_cyc(5);
    chk("badpar.err_cnt",   n_ferr - e0, 1);
    chk("badpar.valid_cnt", n_valid - v0, 0);
    @(negedge clk);
    chk("badpar.btn_held",  o_buttons, btn_hold);
    send_and_check("after_badpar", 8'h2C, 8'h7F, 8'h80);

    // Misaligned byte0
    v0 = n_valid; e0 = n_ferr;
    send_frame(8'h00, 1'b0, 11);
    wait_cyc(5);
    chk("align.err_cnt",   n_ferr - e0, 1);
    chk("align.valid_cnt", n_valid - v0, 0);
    send_and_check("after_align", 8'h0F, 8'h01, 8'h02);

    // Timeout after 5 bits of byte1
    v0 = n_valid; e0 = n_ferr;
    send_frame(8'h09, 1'b0, 11);
    send_frame(8'h44, 1'b0, 5);
    wait_cyc(TO + 100);
    chk("timeout.err_cnt",   n_ferr - e0, 1);
    chk("timeout.valid_cnt", n_valid - v0, 0);
    send_and_check("after_timeout", 8'h3B, 8'hFF, 8'h01);

    // Reset mid-byte
    v0 = n_valid; e0 = n_ferr;
    send_frame(8'h0C, 1'b0, 11);
    send_frame(8'h21, 1'b0, 4);
    @(negedge clk);
    arst_n = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    chk("rstmid.dx",  o_mouse_dx, 0);
    chk("rstmid.dy",  o_mouse_dy, 0);
    chk("rstmid.btn", o_buttons, 0);
    chk("rstmid.err", o_frame_error, 0);
    arst_n = 1'b1;
    wait_cyc(TO + 100);
    chk("rstmid.valid_cnt", n_valid - v0, 0);
    chk("rstmid.err_cnt",   n_ferr - e0, 0);
    send_and_check("after_rst", 8'h2A, 8'h11, 8'hF0);

    // Randomized packets with arbitrary sign/overflow/button bits
    for (int i = 0; i < 8; i++) begin
      rb0 = 8'($urandom) | 8'h08;
      rb1 = 8'($urandom);
      rb2 = 8'($urandom);
      send_and_check($sformatf("rand%0d", i), rb0, rb1, rb2);
    end

    chk("no_leak", n_leak, 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
